// File: rtl/ro_adc_updown_reader.sv
// ro_adc_updown_reader
//   Digital back end for the ring-oscillator 1-bit ADC. The asynchronous
//   comparator bit is synchronised, then accumulated as +1 (high) / -1 (low)
//   over a window of WIN_LEN clk cycles. The signed, saturating result is
//   handed to downstream logic over a valid/ready handshake.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   adc_bit       comparator output, asynchronous to clk
//   start         1-cycle request to begin a conversion (ignored while busy)
//   cont_mode     1: restart a window right after each handshake
//   result        signed window result (two's complement, CNT_W bits)
//   result_valid  result/overflow valid and held stable
//   result_ready  consumer accepts the result
//   overflow      saturation occurred during the reported window
//   busy          conversion in progress or result pending
module ro_adc_updown_reader #(
  parameter int CNT_W       = 12,
  parameter int WIN_LEN     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adc_bit,
  input  logic             start,
  input  logic             cont_mode,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int CB = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CB-1:0]    CNT_LAST = CB'(WIN_LEN - 1);
  localparam logic [CB-1:0]    CNT_ONE  = CB'(1);
  localparam logic [CNT_W-1:0] ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // Symmetric clamp: the most negative two's-complement code is never used.
  localparam logic [CNT_W-1:0] ACC_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] ACC_MIN  = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};

  // S_DONE is the extra cycle between the last sample and result_valid,
  // which sets the start-to-valid latency at WIN_LEN+1 edges.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_bit;

  logic [CNT_W-1:0] acc, acc_nxt;
  logic [CB-1:0]    cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [CNT_W-1:0] result_nxt;
  logic             overflow_nxt;
  logic             valid_nxt;

  // Synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], adc_bit};
  end

  assign s_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      acc          <= acc_nxt;
      cnt          <= cnt_nxt;
      ovf          <= ovf_nxt;
      result       <= result_nxt;
      overflow     <= overflow_nxt;
      result_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    ovf_nxt      = ovf;
    result_nxt   = result;
    overflow_nxt = overflow;
    valid_nxt    = result_valid;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end

      S_RUN: begin
        if (s_bit) begin
          if (acc == ACC_MAX) ovf_nxt = 1'b1;
          else                acc_nxt = acc + ACC_ONE;
        end else begin
          if (acc == ACC_MIN) ovf_nxt = 1'b1;
          else                acc_nxt = acc - ACC_ONE;
        end
        if (cnt == CNT_LAST) state_nxt = S_DONE;
        else                 cnt_nxt   = cnt + CNT_ONE;
      end

      S_DONE: begin
        result_nxt   = acc;
        overflow_nxt = ovf;
        valid_nxt    = 1'b1;
        state_nxt    = S_HOLD;
      end

      S_HOLD: begin
        if (result_ready) begin
          valid_nxt = 1'b0;
          if (cont_mode) begin
            state_nxt = S_RUN;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ro_adc_updown_reader.sv
module tb_ro_adc_updown_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adc_bit;
  logic        cont_mode;
  logic        result_ready;
  logic        start_a, start_b, start_c;

  logic [11:0] res_a;
  logic [7:0]  res_b;
  logic [11:0] res_c;
  logic        valid_a, valid_b, valid_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        busy_a, busy_b, busy_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ro_adc_updown_reader #(.CNT_W(12), .WIN_LEN(256), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .adc_bit(adc_bit), .start(start_a),
    .cont_mode(cont_mode), .result(res_a), .result_valid(valid_a),
    .result_ready(result_ready), .overflow(ovf_a), .busy(busy_a));

  ro_adc_updown_reader #(.CNT_W(8), .WIN_LEN(200), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .adc_bit(adc_bit), .start(start_b),
    .cont_mode(cont_mode), .result(res_b), .result_valid(valid_b),
    .result_ready(result_ready), .overflow(ovf_b), .busy(busy_b));

  ro_adc_updown_reader #(.CNT_W(12), .WIN_LEN(1), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .adc_bit(adc_bit), .start(start_c),
    .cont_mode(cont_mode), .result(res_c), .result_valid(valid_c),
    .result_ready(result_ready), .overflow(ovf_c), .busy(busy_c));

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_valid(input int which);
    case (which)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  task automatic pulse_start(input int which);
    case (which)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Counts edges after the start edge until valid is seen.
  task automatic wait_valid(input int which, output int n);
    n = 0;
    while (!pick_valid(which) && n < 1000) begin
      tick();
      n++;
    end
    if (!pick_valid(which)) check("valid_timeout", 0, 1);
  endtask

  // Toggles adc_bit on every falling edge (asynchronous phase to the
  // sampling edge) until valid is seen.
  task automatic wait_valid_tog(input int which);
    int n;
    n = 0;
    while (!pick_valid(which) && n < 1000) begin
      @(negedge clk);
      adc_bit = ~adc_bit;
      n++;
    end
    if (!pick_valid(which)) check("valid_timeout_tog", 0, 1);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    int n;
    int r0, o0;
    logic stable, seen;

    rst_n        = 1'b0;
    adc_bit      = 1'b1;
    cont_mode    = 1'b0;
    result_ready = 1'b1;
    start_a      = 1'b0;
    start_b      = 1'b0;
    start_c      = 1'b0;
    #22;
    check("rst_result", int'(res_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_overflow", int'(ovf_a), 0);
    check("rst_busy", int'(busy_a), 0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Constant high: +256, valid WIN_LEN+1 edges after the start edge.
    pulse_start(0);
    wait_valid(0, n);
    check("t1_latency", n, 257);
    check("t1_result", int'($signed(res_a)), 256);
    check("t1_overflow", int'(ovf_a), 0);
    tick();
    check("t1_valid_drop", int'(valid_a), 0);
    check("t1_idle", int'(busy_a), 0);

    // Constant low: -256 = 12'hF00.
    adc_bit = 1'b0;
    repeat (4) tick();
    pulse_start(0);
    wait_valid(0, n);
    check("t2_latency", n, 257);
    check("t2_result", int'(res_a), 'hF00);
    check("t2_overflow", int'(ovf_a), 0);
    tick();

    // Alternating input: result near zero.
    pulse_start(0);
    wait_valid_tog(0);
    check("t3_range", int'(iabs(int'($signed(res_a))) <= 2), 1);
    check("t3_overflow", int'(ovf_a), 0);
    tick();

    // Consumer stalls for 40 cycles; start pulses meanwhile are dropped.
    adc_bit      = 1'b1;
    result_ready = 1'b0;
    repeat (4) tick();
    pulse_start(0);
    wait_valid(0, n);
    r0 = int'(res_a);
    o0 = int'(ovf_a);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10 || i == 20) start_a = 1'b1;
      tick();
      start_a = 1'b0;
      if (int'(res_a) != r0 || int'(ovf_a) != o0 || !valid_a || !busy_a)
        stable = 1'b0;
    end
    check("t4_stable", int'(stable), 1);
    check("t4_result", int'($signed(res_a)), 256);
    result_ready = 1'b1;
    tick();
    check("t4_valid_drop", int'(valid_a), 0);
    check("t4_idle", int'(busy_a), 0);
    repeat (5) tick();
    check("t4_no_queue", int'(busy_a), 0);

    // Narrow accumulator: saturation then a clean window.
    pulse_start(1);
    wait_valid(1, n);
    check("t5_latency", n, 201);
    check("t5_result", int'($signed(res_b)), 127);
    check("t5_overflow", int'(ovf_b), 1);
    tick();
    pulse_start(1);
    wait_valid_tog(1);
    check("t5b_range", int'(iabs(int'($signed(res_b))) <= 2), 1);
    check("t5b_overflow", int'(ovf_b), 0);
    tick();

    // Single-sample window.
    adc_bit = 1'b1;
    repeat (4) tick();
    pulse_start(2);
    wait_valid(2, n);
    check("w1_latency", n, 2);
    check("w1_pos", int'($signed(res_c)), 1);
    tick();
    adc_bit = 1'b0;
    repeat (4) tick();
    pulse_start(2);
    wait_valid(2, n);
    check("w1_neg", int'($signed(res_c)), -1);
    tick();

    // Continuous mode, then reset in the middle of a window.
    adc_bit   = 1'b1;
    cont_mode = 1'b1;
    repeat (4) tick();
    pulse_start(0);
    wait_valid(0, n);
    check("t6_first", int'($signed(res_a)), 256);
    tick();
    check("t6_valid_drop", int'(valid_a), 0);
    check("t6_busy_cont", int'(busy_a), 1);
    wait_valid(0, n);
    check("t6_period", n, 257);
    check("t6_second", int'($signed(res_a)), 256);
    tick();
    repeat (100) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_result", int'(res_a), 0);
    check("t6_rst_valid", int'(valid_a), 0);
    check("t6_rst_busy", int'(busy_a), 0);
    check("t6_rst_overflow", int'(ovf_a), 0);
    #3;
    rst_n     = 1'b1;
    cont_mode = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (valid_a || busy_a) seen = 1'b1;
    end
    check("t6_no_valid", int'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
